mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DM_TIMEOUT, default 64: maximum wait cycles for dm_ack before abort.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports op_i in 6, memAddr_i in 32, memData_i in 32: op, effective address and store data from EX.
REQ-005 SHALL have ports regcData_i in 32, regcAddr_i in 5, regcWrite_i in 1: ALU result and write-back control from EX.
REQ-006 SHALL have ports dm_req out 1, dm_we out 1, dm_addr out 32, dm_wdata out 32, dm_be out 4: data-memory request.
REQ-007 SHALL have ports dm_rdata in 32, dm_ack in 1: data-memory response.
REQ-008 SHALL have ports regcData out 32, regcAddr out 5, regcWrite out 1: toward the register file.
REQ-009 SHALL have ports stall out 1 (upstream holds inputs), bus_err out 1, adel out 1, ades out 1.

Function
REQ-010 SHALL recognise memory ops lw, lh, lhu, lb, lbu, sw, sh, sb; all other ops are non-memory ops.
REQ-011 SHALL implement states IDLE, BUSY, DONE.
REQ-012 IDLE with non-memory op: regcData/regcAddr/regcWrite pass combinationally from inputs, stall=0, dm_req=0.
REQ-013 IDLE with memory op: stall=1, regcWrite=0; at the clock edge, capture op, address, store data, regcAddr_i and regcWrite_i, then go to BUSY.
REQ-014 BUSY: dm_req=1; dm_we, dm_addr, dm_wdata and dm_be come from the captured values and stay stable until dm_ack; stall=1.
REQ-015 BUSY with dm_ack=1: latch dm_rdata and go to DONE; dm_req drops in the following cycle.
REQ-016 DONE: one cycle, stall=0, regcAddr=captured address; loads drive regcWrite=captured enable and regcData=extracted result; stores drive regcWrite=0; then return to IDLE.
REQ-017 Load latency SHALL be ack cycle + 1: minimum 3 cycles from op arrival to write-back.
REQ-018 dm_addr SHALL be {addr[31:2],2'b00}; byte lanes are little-endian.
REQ-019 dm_be: sw=1111; sh=0011 if addr[1]=0, else 1100; sb=0001<<addr[1:0].
REQ-020 dm_wdata: sh replicates the low halfword into both halves; sb replicates the low byte into all four lanes.
REQ-021 Load extraction: lb/lh sign-extend the selected lane; lbu/lhu zero-extend it; lw returns the full word.
REQ-022 If BUSY lasts DM_TIMEOUT cycles without dm_ack: drop dm_req, go to DONE with regcWrite=0, and pulse bus_err=1 for the DONE cycle.
REQ-023 dm_ack outside BUSY SHALL be ignored.
REQ-024 The memory op still present on op_i in DONE SHALL NOT start a new access; IDLE samples only the next op.

Reset
REQ-025 When rst=1 at a clock edge: state=IDLE, captured registers=0, timeout counter=0.
REQ-026 Reset during BUSY: dm_req=0 from the next cycle; the access is abandoned with no write-back.
REQ-027 While rst=1: stall, dm_req, regcWrite, bus_err, adel and ades SHALL all be 0, and regcData=0.

Configuration
REQ-028 With macro MEM_ALIGN_CHECK_EN defined, a misaligned access (lw/sw addr[1:0]!=0; lh/lhu/sh addr[0]!=0) SHALL issue no request, SHALL go IDLE->DONE with regcWrite=0, and SHALL pulse adel (loads) or ades (stores) for the DONE cycle.
REQ-029 Without MEM_ALIGN_CHECK_EN: adel=ades=0; sw/lw ignore addr[1:0]; sh/lh/lhu ignore addr[0].

Structure
REQ-030 Op encodings and RST_ENABLE/VALID/ZERO constants SHALL live in the shared definitions package def; state encodings stay local.
REQ-031 Lane select/extend logic SHALL be one sub-module, mem_lane_align: be/wdata generation plus load extraction, purely combinational.

Verification
REQ-032 lw at 0x100 with dm_ack 2 cycles after dm_req and dm_rdata=0xDEADBEEF -> regcData=0xDEADBEEF, regcWrite=1 for one cycle; stall high until DONE.
REQ-033 lb at 0x103 with rdata=0x80112233 -> regcData=0xFFFFFF80; lbu at the same address -> 0x00000080.
REQ-034 sh at 0x202 with data 0x0000ABCD -> dm_be=1100, dm_wdata=0xABCDABCD, dm_we=1, regcWrite=0.
REQ-035 lw with dm_ack never asserted, DM_TIMEOUT=64 -> dm_req high 64 cycles, then bus_err=1 one cycle, regcWrite=0, stall=0.
REQ-036 rst asserted in the 2nd BUSY cycle -> dm_req=0 next cycle, no write-back; a following or (regcData_i=5) passes through the same cycle.
REQ-037 With MEM_ALIGN_CHECK_EN, lw at 0x101 -> adel=1 one cycle, dm_req never asserted; without the macro, dm_addr=0x100.

Source files
------------

// File: rtl/def_pkg.sv
//------------------------------------------------------------------------------
// Module  : def (package)
// Brief   : Shared opcode encodings, reset/valid constants and op classifiers.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package def;

    localparam logic        RST_ENABLE = 1'b1;
    localparam logic        VALID      = 1'b1;
    localparam logic [31:0] ZERO       = 32'h0000_0000;

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_OR  = 6'h0D;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_lane_align.sv
//------------------------------------------------------------------------------
// Module  : mem_lane_align
// Brief   : Little-endian byte-lane enables, store-data replication and load
//           extraction (sign/zero extend). Purely combinational.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_lane_align
    import def::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata_out
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr_lo)
            2'd0:    w_byte = rdata_in[7:0];
            2'd1:    w_byte = rdata_in[15:8];
            2'd2:    w_byte = rdata_in[23:16];
            default: w_byte = rdata_in[31:24];
        endcase
        // Halfword lane chosen by addr[1] only; addr[0] is ignored here.
        w_half = addr_lo[1] ? rdata_in[31:16] : rdata_in[15:0];
    end

    always_comb begin
        be        = 4'b0000;
        wdata     = wdata_in;
        rdata_out = rdata_in;
        case (op)
            OP_SW: be = 4'b1111;
            OP_SH: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wdata_in[15:0]}};
            end
            OP_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{wdata_in[7:0]}};
            end
            OP_LB:   rdata_out = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  rdata_out = {24'h0, w_byte};
            OP_LH:   rdata_out = {{16{w_half[15]}}, w_half};
            OP_LHU:  rdata_out = {16'h0, w_half};
            default: rdata_out = rdata_in;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// Module  : mem_stage
// Brief   : Pipeline MEM stage: issues data-memory requests, stalls upstream
//           until the response, and extracts load results for write-back.
//           Optional macro MEM_ALIGN_CHECK_EN enables misalignment exceptions.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage
    import def::*;
#(
    parameter int DM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op_i,
    input  logic [31:0] memAddr_i,
    input  logic [31:0] memData_i,
    input  logic [31:0] regcData_i,
    input  logic [4:0]  regcAddr_i,
    input  logic        regcWrite_i,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic [31:0] regcData,
    output logic [4:0]  regcAddr,
    output logic        regcWrite,
    output logic        stall,
    output logic        bus_err,
    output logic        adel,
    output logic        ades
);

    localparam int CNT_W = (DM_TIMEOUT > 1) ? $clog2(DM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic [5:0]      r_op;
    logic [31:0]     r_addr, r_wdata, r_rdata;
    logic [4:0]      r_rc_addr;
    logic            r_rc_write, r_bus_err, r_adel, r_ades;
    logic [CNT_W-1:0] r_cnt;

    logic            w_is_mem, w_misalign, w_timeout;
    logic [31:0]     w_load_data;

    assign w_is_mem  = is_load(op_i) || is_store(op_i);
    assign w_timeout = !dm_ack && (r_cnt == c_cnt_last);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (((op_i == OP_LW) || (op_i == OP_SW)) && (memAddr_i[1:0] != 2'b00)) ||
                        (((op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH)) && memAddr_i[0]);
`else
    assign w_misalign = 1'b0;
`endif

    mem_lane_align u_align (
        .op        (r_op),
        .addr_lo   (r_addr[1:0]),
        .wdata_in  (r_wdata),
        .rdata_in  (r_rdata),
        .be        (dm_be),
        .wdata     (dm_wdata),
        .rdata_out (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) r_state <= IDLE;
        else                   r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_is_mem) w_state_next = w_misalign ? DONE : BUSY;
            BUSY:    if (dm_ack || w_timeout) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_op       <= OP_NOP;
            r_addr     <= ZERO;
            r_wdata    <= ZERO;
            r_rdata    <= ZERO;
            r_rc_addr  <= 5'd0;
            r_rc_write <= 1'b0;
            r_bus_err  <= 1'b0;
            r_adel     <= 1'b0;
            r_ades     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_is_mem) begin
                    r_op       <= op_i;
                    r_addr     <= memAddr_i;
                    r_wdata    <= memData_i;
                    r_rc_addr  <= regcAddr_i;
                    r_rc_write <= regcWrite_i;
                    r_bus_err  <= 1'b0;
                    r_adel     <= w_misalign && is_load(op_i);
                    r_ades     <= w_misalign && is_store(op_i);
                    r_cnt      <= '0;
                end
                BUSY: begin
                    if (dm_ack)         r_rdata   <= dm_rdata;
                    else if (w_timeout) r_bus_err <= 1'b1;
                    else                r_cnt     <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dm_we   = is_store(r_op);
    assign dm_addr = {r_addr[31:2], 2'b00};

    // All control outputs are forced low while reset is held.
    always_comb begin
        dm_req    = 1'b0;
        stall     = 1'b0;
        regcData  = regcData_i;
        regcAddr  = regcAddr_i;
        regcWrite = regcWrite_i;
        bus_err   = 1'b0;
        adel      = 1'b0;
        ades      = 1'b0;
        case (r_state)
            IDLE: if (w_is_mem) begin
                stall     = 1'b1;
                regcWrite = 1'b0;
            end
            BUSY: begin
                dm_req    = VALID;
                stall     = 1'b1;
                regcWrite = 1'b0;
            end
            DONE: begin
                regcAddr  = r_rc_addr;
                regcData  = w_load_data;
                regcWrite = is_load(r_op) && r_rc_write && !r_bus_err && !r_adel;
                bus_err   = r_bus_err;
                adel      = r_adel;
                ades      = r_ades;
            end
            default: ;
        endcase
        if (rst == RST_ENABLE) begin
            dm_req    = 1'b0;
            stall     = 1'b0;
            regcWrite = 1'b0;
            regcData  = ZERO;
            bus_err   = 1'b0;
            adel      = 1'b0;
            ades      = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_stage
// Brief   : Directed self-checking bench for mem_stage.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;
    import def::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op_i;
    logic [31:0] memAddr_i, memData_i, regcData_i;
    logic [4:0]  regcAddr_i;
    logic        regcWrite_i;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] regcData;
    logic [4:0]  regcAddr;
    logic        regcWrite, stall, bus_err, adel, ades;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.DM_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .op_i(op_i), .memAddr_i(memAddr_i), .memData_i(memData_i),
        .regcData_i(regcData_i), .regcAddr_i(regcAddr_i), .regcWrite_i(regcWrite_i),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .regcData(regcData), .regcAddr(regcAddr), .regcWrite(regcWrite),
        .stall(stall), .bus_err(bus_err), .adel(adel), .ades(ades)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one memory op, ack after ack_wait BUSY cycles, check request and write-back.
    task automatic access(input string tag, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int ack_wait,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rc);
        op_i = op; memAddr_i = addr; memData_i = wdata;
        regcAddr_i = 5'd7; regcWrite_i = 1'b1; regcData_i = 32'h1111_1111;
        #1;
        chk({tag, ".stall_idle"}, 32'(stall), 32'd1);
        chk({tag, ".wr_idle"}, 32'(regcWrite), 32'd0);
        step();
        for (int i = 0; i < ack_wait; i++) begin
            chk({tag, ".req_wait"}, 32'(dm_req), 32'd1);
            step();
        end
        chk({tag, ".req"}, 32'(dm_req), 32'd1);
        chk({tag, ".addr"}, dm_addr, {addr[31:2], 2'b00});
        chk({tag, ".we"}, 32'(dm_we), 32'(is_store(op)));
        if (is_store(op)) begin
            chk({tag, ".be"}, 32'(dm_be), 32'(exp_be));
            chk({tag, ".wdata"}, dm_wdata, exp_wdata);
        end
        dm_ack = 1'b1; dm_rdata = rdata;
        step();
        dm_ack = 1'b0;
        chk({tag, ".stall_done"}, 32'(stall), 32'd0);
        chk({tag, ".req_done"}, 32'(dm_req), 32'd0);
        chk({tag, ".wr_done"}, 32'(regcWrite), 32'(is_load(op)));
        chk({tag, ".waddr_done"}, 32'(regcAddr), 32'd7);
        if (is_load(op)) chk({tag, ".rdata"}, regcData, exp_rc);
        step();
        op_i = OP_NOP; regcWrite_i = 1'b0;
        #1;
    endtask

    initial begin
        int cyc;
        rst = 1'b1; op_i = OP_OR; memAddr_i = '0; memData_i = '0;
        regcData_i = 32'h9; regcAddr_i = 5'd1; regcWrite_i = 1'b1;
        dm_rdata = '0; dm_ack = 1'b0;
        step(); step();
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.req", 32'(dm_req), 32'd0);
        chk("rst.wr", 32'(regcWrite), 32'd0);
        chk("rst.data", regcData, 32'd0);
        chk("rst.bus_err", 32'(bus_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("pass.data", regcData, 32'h9);
        chk("pass.wr", 32'(regcWrite), 32'd1);
        dm_ack = 1'b1;
        step();
        chk("ack_idle.req", 32'(dm_req), 32'd0);
        chk("ack_idle.stall", 32'(stall), 32'd0);
        dm_ack = 1'b0;

        access("lw",  OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 2, 4'h0, 32'h0, 32'hDEADBEEF);
        access("lb",  OP_LB,  32'h103, 32'h0, 32'h80112233, 0, 4'h0, 32'h0, 32'hFFFFFF80);
        access("lbu", OP_LBU, 32'h103, 32'h0, 32'h80112233, 1, 4'h0, 32'h0, 32'h00000080);
        access("lh",  OP_LH,  32'h102, 32'h0, 32'h80011234, 0, 4'h0, 32'h0, 32'hFFFF8001);
        access("lhu", OP_LHU, 32'h100, 32'h0, 32'h8001F234, 0, 4'h0, 32'h0, 32'h0000F234);
        access("sh",  OP_SH,  32'h202, 32'h0000ABCD, 32'h0, 0, 4'b1100, 32'hABCDABCD, 32'h0);
        access("sb",  OP_SB,  32'h101, 32'h0000005A, 32'h0, 0, 4'b0010, 32'h5A5A5A5A, 32'h0);
        access("sw",  OP_SW,  32'h30C, 32'h12345678, 32'h0, 0, 4'b1111, 32'h12345678, 32'h0);

        // Timeout: count dm_req-high cycles, bounded.
        op_i = OP_LW; memAddr_i = 32'h400; regcWrite_i = 1'b1;
        step();
        op_i = OP_NOP;
        cyc = 0;
        while (dm_req && cyc < 200) begin
            cyc++;
            step();
        end
        chk("tmo.req_cycles", 32'(cyc), 32'd64);
        chk("tmo.bus_err", 32'(bus_err), 32'd1);
        chk("tmo.wr", 32'(regcWrite), 32'd0);
        chk("tmo.stall", 32'(stall), 32'd0);
        step();
        chk("tmo.bus_err_clr", 32'(bus_err), 32'd0);

        // Reset in the second BUSY cycle abandons the load.
        op_i = OP_LW; memAddr_i = 32'h100; regcWrite_i = 1'b1;
        step();
        step();
        chk("rstb.req_busy2", 32'(dm_req), 32'd1);
        rst = 1'b1;
        step();
        chk("rstb.req", 32'(dm_req), 32'd0);
        chk("rstb.wr", 32'(regcWrite), 32'd0);
        rst = 1'b0; op_i = OP_OR; regcData_i = 32'd5; regcAddr_i = 5'd2; regcWrite_i = 1'b1;
        #1;
        chk("rstb.or_data", regcData, 32'd5);
        chk("rstb.or_wr", 32'(regcWrite), 32'd1);
        chk("rstb.or_stall", 32'(stall), 32'd0);
        step();
        chk("rstb.no_req", 32'(dm_req), 32'd0);

        // Misaligned word load.
        op_i = OP_LW; memAddr_i = 32'h101; regcWrite_i = 1'b1;
        step();
        op_i = OP_NOP;
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis.req", 32'(dm_req), 32'd0);
        chk("mis.adel", 32'(adel), 32'd1);
        chk("mis.wr", 32'(regcWrite), 32'd0);
        step();
        chk("mis.adel_clr", 32'(adel), 32'd0);
`else
        chk("mis.req", 32'(dm_req), 32'd1);
        chk("mis.addr", dm_addr, 32'h100);
        chk("mis.adel", 32'(adel), 32'd0);
        dm_ack = 1'b1; dm_rdata = 32'h0BADF00D;
        step();
        dm_ack = 1'b0;
        chk("mis.data", regcData, 32'h0BADF00D);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
